stopwatch_ctrl: RTL and testbench

Mode controller and tick scheduler for the stopwatch counter chain. It owns the RUN / PAUSED / ADJUST mode, divides the system clock into 1 Hz run ticks and 2 Hz adjust ticks, and drives single-cycle enables into the seconds and minutes counters (`counter` instances, MAX=60). It also produces the blink strobe that the display uses to flash the field being adjusted.

---
 rtl/stopwatch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: RUN / PAUSED / ADJUST state machine, 1 Hz and 2 Hz
// tick dividers, and the registered enables / blink strobe for the counter chain.
module stopwatch_ctrl #(
   parameter int TICK_1HZ  = 100_000_000,
   parameter int TICK_2HZ  = 50_000_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pause,
   input  logic       i_adj,
   input  logic       i_sel,
   input  logic       i_sec_carry,
   output logic       o_sec_en,
   output logic       o_min_en,
   output logic       o_blink,
   output logic [1:0] o_mode
);

   localparam int W1 = $clog2(TICK_1HZ);
   localparam int W2 = $clog2(TICK_2HZ);
   localparam int WB = $clog2(BLINK_DIV);

   localparam logic [W1-1:0] C1_LAST = W1'(TICK_1HZ - 1);
   localparam logic [W2-1:0] C2_LAST = W2'(TICK_2HZ - 1);
   localparam logic [WB-1:0] CB_LAST = WB'(BLINK_DIV - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_PAUSED = 2'b01,
      ST_ADJUST = 2'b10
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_pause_q;
   logic [W1-1:0]   r_div1;
   logic [W2-1:0]   r_div2;
   logic [WB-1:0]   r_divb;
   logic            r_sec_en;
   logic            r_min_en;
   logic            r_blink;

   logic            w_pause_ev;
   logic            w_adj_stay;
   logic            w_wrap1;
   logic            w_wrap2;
   logic            w_wrapb;
   logic            w_sec_en_d;
   logic            w_min_en_d;

   assign w_pause_ev = i_pause & ~r_pause_q;

   // Next state and next enable values. ADJUST work is gated on staying in
   // ADJUST, so the exit edge neither toggles blink nor issues an enable.
   always_comb begin
      w_next     = r_state;
      w_sec_en_d = 1'b0;
      w_min_en_d = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (i_adj)
               w_next = ST_ADJUST;
            else if (w_pause_ev)
               w_next = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (i_adj)
               w_next = ST_ADJUST;
            else if (w_pause_ev)
               w_next = ST_RUN;
         end
         ST_ADJUST: begin
            if (!i_adj)
               w_next = ST_PAUSED;
         end
         default: w_next = ST_RUN;
      endcase

      w_adj_stay = (r_state == ST_ADJUST) && (w_next == ST_ADJUST);
      w_wrap1    = (r_state == ST_RUN) && (r_div1 == C1_LAST);
      w_wrap2    = w_adj_stay && (r_div2 == C2_LAST);
      w_wrapb    = w_adj_stay && (r_divb == CB_LAST);

      if (w_wrap1) begin
         w_sec_en_d = 1'b1;
         w_min_en_d = i_sec_carry;
      end else if (w_wrap2) begin
         w_sec_en_d = i_sel;
         w_min_en_d = ~i_sel;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_RUN;
         r_pause_q <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_pause_q <= i_pause;
      end
   end

   // The 1 Hz divider freezes while PAUSED and drops any partial second in ADJUST.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div1 <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_wrap1)
            r_div1 <= '0;
         else
            r_div1 <= r_div1 + 1'b1;
      end else if (r_state == ST_ADJUST) begin
         r_div1 <= '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_div2 <= '0;
      end else if (w_adj_stay) begin
         if (w_wrap2)
            r_div2 <= '0;
         else
            r_div2 <= r_div2 + 1'b1;
      end else begin
         r_div2 <= '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_divb  <= '0;
         r_blink <= 1'b0;
      end else if (w_adj_stay) begin
         if (w_wrapb) begin
            r_divb  <= '0;
            r_blink <= ~r_blink;
         end else begin
            r_divb  <= r_divb + 1'b1;
         end
      end else begin
         r_divb  <= '0;
         r_blink <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sec_en <= 1'b0;
         r_min_en <= 1'b0;
      end else begin
         r_sec_en <= w_sec_en_d;
         r_min_en <= w_min_en_d;
      end
   end

   assign o_sec_en = r_sec_en;
   assign o_min_en = r_min_en;
   assign o_blink  = r_blink;
   assign o_mode   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl with small divider values; expected
// outputs are queued as each vector is driven and compared after the edge.
module tb_stopwatch_ctrl;

   localparam int T1 = 10;
   localparam int T2 = 4;
   localparam int TB = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       pause, adj, sel, carry;
   logic       sec_en, min_en, blink;
   logic [1:0] mode;

   stopwatch_ctrl #(.TICK_1HZ(T1), .TICK_2HZ(T2), .BLINK_DIV(TB)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_pause    (pause),
      .i_adj      (adj),
      .i_sel      (sel),
      .i_sec_carry(carry),
      .o_sec_en   (sec_en),
      .o_min_en   (min_en),
      .o_blink    (blink),
      .o_mode     (mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       p, a, s, c;
      logic       se, me, bl;
      logic [1:0] md;
   } vec_t;

   typedef struct {
      logic [4:0] v;
      int         cyc;
   } exp_t;

   vec_t  tbl[$];
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   string scen;

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: sec/min/blink/mode got %b required %b", name, act, req);
      end
   endtask

   task automatic add(input logic p, a, s, c, se, me, bl, input logic [1:0] md);
      vec_t v;
      v.p = p; v.a = a; v.s = s; v.c = c;
      v.se = se; v.me = me; v.bl = bl; v.md = md;
      tbl.push_back(v);
   endtask

   // Vector n is driven before edge n and its outputs are checked just after it.
   task automatic run_table();
      exp_t e;
      for (int n = 0; n < tbl.size(); n++) begin
         pause = tbl[n].p;
         adj   = tbl[n].a;
         sel   = tbl[n].s;
         carry = tbl[n].c;
         e.v   = {tbl[n].se, tbl[n].me, tbl[n].bl, tbl[n].md};
         e.cyc = n + 1;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check($sformatf("%s cyc%0d", scen, e.cyc), {sec_en, min_en, blink, mode}, e.v);
      end
      tbl.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; pause = 1'b0; adj = 1'b0; sel = 1'b0; carry = 1'b0;
      @(posedge clk);
      #1;
      check({scen, " reset"}, {sec_en, min_en, blink, mode}, 5'b00000);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Free run with carry present only around the second wrap
      scen = "freerun";
      do_reset();
      for (int n = 1; n <= 30; n++)
         add(0, 0, 0, (n >= 19 && n <= 21), (n % 10 == 0), (n == 20), 0, 2'b00);
      run_table();

      // Pause held for several cycles, resume from frozen divider value 5
      scen = "pause";
      do_reset();
      for (int n = 1; n <= 46; n++)
         add((n >= 5 && n <= 10) || (n >= 31 && n <= 40), 0, 0, 0,
             (n == 36 || n == 46), 0, 0,
             (n >= 5 && n <= 30) ? 2'b01 : 2'b00);
      run_table();

      // Adjust minutes, then seconds, exit on a 2 Hz wrap edge, then resume
      scen = "adjust";
      do_reset();
      for (int n = 1; n <= 46; n++) begin
         logic bl, me, se;
         logic [1:0] md;
         bl = (n <= 24) ? logic'(((n - 1) / 3) % 2) : 1'b0;
         me = (n <= 24) && (n >= 5) && (n < 13) && ((n - 1) % 4 == 0);
         se = ((n <= 24) && (n >= 13) && ((n - 1) % 4 == 0)) || (n == 46);
         md = (n <= 24) ? 2'b10 : ((n <= 35) ? 2'b01 : 2'b00);
         add((n == 36), (n <= 24), (n >= 13), (n <= 24), se, me, bl, md);
      end
      run_table();

      // Pause edge coincident with adjust entry is lost; exit lands in PAUSED
      scen = "priority";
      do_reset();
      for (int n = 1; n <= 12; n++)
         add((n >= 4 && n <= 9), (n >= 4 && n <= 8), 0, 0,
             0, (n == 8), (n == 7 || n == 8),
             (n < 4) ? 2'b00 : ((n <= 8) ? 2'b10 : 2'b01));
      run_table();

      // Asynchronous reset in the middle of ADJUST with blink and enable high
      scen = "rstmid";
      do_reset();
      for (int n = 1; n <= 5; n++)
         add(0, 1, 0, 0, 0, (n == 5), (n >= 4), 2'b10);
      run_table();
      #2;
      rst = 1'b1;
      #1;
      check("rstmid async", {sec_en, min_en, blink, mode}, 5'b00000);
      adj = 1'b0;
      #2;
      rst = 1'b0;
      scen = "rstmid after";
      for (int n = 1; n <= 12; n++)
         add(0, 0, 0, 0, (n == 10), 0, 0, 2'b00);
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
